// File: rtl/apb_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// apb_xfer_ctrl
//
// APB master sequencer for the AHB-APB bridge. The block takes one transfer
// request at a time and decodes req_addr[31:26] into one of three peripheral
// selects. A decode hit runs an APB SETUP phase and then an ACCESS phase.
// A decode miss is answered at once with an error response. Every APB output
// and every response output is registered.
//
// Optional feature (macro PREADY_EN):
//   defined   - ACCESS completes when pready=1. Wait cycles are counted, and
//               once the count reaches TIMEOUT with pready still low the
//               transfer is aborted with rsp_err=1.
//   undefined - ACCESS always lasts exactly one cycle and pready is ignored.
//
// Parameters:
//   ADDR_W   address width (decode uses the top six bits)
//   DATA_W   data width
//   TIMEOUT  maximum ACCESS wait cycles before abort (PREADY_EN only)
//
// Ports:
//   hclk       in   clock, all state on rising edge
//   hreset     in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (high only in IDLE)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   transfer address
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle completion pulse
//   rsp_err    out  decode miss or timeout, qualified by rsp_valid
//   rsp_rdata  out  read data, qualified by rsp_valid
//   psel       out  one-hot peripheral select
//   penable    out  ACCESS phase indicator
//   pwrite     out  APB direction
//   paddr      out  APB address
//   pwdata     out  APB write data
//   prdata     in   APB read data
//   pready     in   peripheral ready (ignored without PREADY_EN)
// ---------------------------------------------------------------------------
module apb_xfer_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [2:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int DEC_LSB = ADDR_W - 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [2:0]          r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic [2:0]          w_psel_next;
  logic                w_penable_next;
  logic                w_pwrite_next;
  logic [ADDR_W-1:0]   w_paddr_next;
  logic [DATA_W-1:0]   w_pwdata_next;
  logic                w_rsp_valid_next;
  logic                w_rsp_err_next;
  logic [DATA_W-1:0]   w_rsp_rdata_next;

  logic [2:0]          w_dec_sel;
  logic                w_dec_hit;
  logic                w_done;
  logic                w_abort;

  // Address decode. An all-zero select marks a miss.
  always_comb begin
    w_dec_sel = 3'b000;
    case (req_addr[ADDR_W-1:DEC_LSB])
      6'b100000: w_dec_sel = 3'b001;
      6'b100001: w_dec_sel = 3'b010;
      6'b100010: w_dec_sel = 3'b100;
      default:   w_dec_sel = 3'b000;
    endcase
  end

  assign w_dec_hit = |w_dec_sel;

`ifdef PREADY_EN
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  logic [CNT_W-1:0] r_cnt;

  // pready wins over the timeout in the cycle the count reaches TIMEOUT.
  assign w_done  = pready;
  assign w_abort = !pready && (r_cnt == CNT_W'(TIMEOUT));

  // The wait counter is cleared in SETUP, so it starts at zero on entry to ACCESS.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !pready && !w_abort) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_pready;

  // A single ACCESS cycle always completes. pready is deliberately ignored.
  assign w_done          = 1'b1;
  assign w_abort         = 1'b0;
  assign w_unused_pready = pready;
`endif

  // State register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A decode miss stays in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && w_dec_hit) begin
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_done || w_abort) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic. It computes the next value of each registered output.
  // paddr, pwdata and pwrite hold their value unless a new request is
  // captured. The response outputs default to zero, which makes them a
  // single-cycle pulse.
  always_comb begin
    w_psel_next      = r_psel;
    w_penable_next   = r_penable;
    w_pwrite_next    = r_pwrite;
    w_paddr_next     = r_paddr;
    w_pwdata_next    = r_pwdata;
    w_rsp_valid_next = 1'b0;
    w_rsp_err_next   = 1'b0;
    w_rsp_rdata_next = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_dec_hit) begin
            w_psel_next    = w_dec_sel;
            w_penable_next = 1'b0;
            w_pwrite_next  = req_write;
            w_paddr_next   = req_addr;
            w_pwdata_next  = req_wdata;
          end else begin
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        w_penable_next = 1'b1;
      end
      ST_ACCESS: begin
        if (w_done) begin
          w_psel_next      = 3'b000;
          w_penable_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_pwrite ? '0 : prdata;
        end else if (w_abort) begin
          w_psel_next      = 3'b000;
          w_penable_next   = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = 1'b1;
        end
      end
      default: begin
        w_psel_next    = 3'b000;
        w_penable_next = 1'b0;
      end
    endcase
  end

  // Output registers. Reset clears psel and penable asynchronously, so an
  // in-flight transfer is dropped on the APB side right away.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_psel      <= 3'b000;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_psel      <= w_psel_next;
      r_penable   <= w_penable_next;
      r_pwrite    <= w_pwrite_next;
      r_paddr     <= w_paddr_next;
      r_pwdata    <= w_pwdata_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_xfer_ctrl
//
// Directed and randomized bench for apb_xfer_ctrl. Expected behaviour comes
// from a transaction-level model. That model decodes the address from the
// region table, and it works out the ACCESS length, the error flag and the
// read data from the wait-state count with plain arithmetic. The bench
// prints one line per transaction.
// ---------------------------------------------------------------------------
module tb_apb_xfer_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;
`ifdef PREADY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic              hclk = 1'b0;
  logic              hreset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [2:0]        psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  int n_assert = 0;
  int n_fail   = 0;

  apb_xfer_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TMO)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Region table: 0x20 -> slave 0, 0x21 -> slave 1, 0x22 -> slave 2.
  function automatic logic [2:0] ref_sel(input logic [31:0] addr);
    int region;
    region = int'(addr >> 26);
    if (region == 32) return 3'b001;
    if (region == 33) return 3'b010;
    if (region == 34) return 3'b100;
    return 3'b000;
  endfunction

  // Run one request, starting at a negedge, and check every cycle up to and
  // including the response cycle. `waits` is the number of cycles pready is
  // held low, and it only has an effect when PREADY_EN is built in.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits);
    logic [2:0]  sel;
    logic [31:0] exp_rd;
    bit          abort;
    int          n_acc;
    sel    = ref_sel(addr);
    abort  = PE && (waits > TMO);
    n_acc  = !PE ? 1 : (abort ? TMO + 1 : waits + 1);
    exp_rd = (wr || abort) ? 32'h0 : rd;

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    prdata    = rd;
    pready    = 1'b0;
    check("accept_ready", req_ready, 1);
    @(negedge hclk);
    req_valid = 1'b0;
    if (sel == 3'b000) begin
      check("miss_rsp_valid", rsp_valid, 1);
      check("miss_rsp_err", rsp_err, 1);
      check("miss_rsp_rdata", rsp_rdata, 0);
      check("miss_psel", psel, 0);
      check("miss_req_ready", req_ready, 1);
    end else begin
      check("setup_psel", psel, sel);
      check("setup_penable", penable, 0);
      check("setup_paddr", paddr, addr);
      check("setup_pwrite", pwrite, wr);
      check("setup_pwdata", pwdata, wd);
      check("setup_rsp_valid", rsp_valid, 0);
      check("setup_req_ready", req_ready, 0);
      for (int i = 0; i < n_acc; i++) begin
        @(negedge hclk);
        check("access_psel", psel, sel);
        check("access_penable", penable, 1);
        check("access_paddr", paddr, addr);
        check("access_rsp_valid", rsp_valid, 0);
        pready = PE ? (i >= waits) : 1'b0;
      end
      @(negedge hclk);
      pready = 1'b0;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, abort);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_psel", psel, 0);
      check("rsp_penable", penable, 0);
      check("rsp_req_ready", req_ready, 1);
      check("rsp_paddr_kept", paddr, addr);
      check("rsp_pwdata_kept", pwdata, wd);
    end
    $display("xfer %s addr=%08h sel=%03b waits=%0d err=%0b rdata=%08h", wr ? "WR" : "RD",
             addr, sel, waits, (sel == 3'b000) || abort, exp_rd);
  endtask

  task automatic idle_check();
    @(negedge hclk);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_rsp_err", rsp_err, 0);
    check("idle_rsp_rdata", rsp_rdata, 0);
    check("idle_psel", psel, 0);
    check("idle_penable", penable, 0);
  endtask

  // Absolute bound on run time.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  bb_sel [6];
    logic        bb_pen [6];
    logic        bb_rv  [6];
    logic [31:0] bb_rd  [6];
    bb_sel = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000};
    bb_pen = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bb_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bb_rd  = '{32'h0, 32'h0, 32'hCAFE_0001, 32'h0, 32'h0, 32'hCAFE_0002};

    hreset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;

    // Reset state
    repeat (2) @(negedge hclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_ready", req_ready, 1);
    hreset = 1'b0;
    idle_check();

    // Directed transfers
    do_xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
    idle_check();
    do_xfer(1'b0, 32'h8800_0004, 32'h0, 32'h1234_5678, 0);
    idle_check();
    do_xfer(1'b0, 32'h4000_0000, 32'h0, 32'h5555_AAAA, 0);
    idle_check();

    // Back-to-back reads with req_valid held
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8400_0000;
    prdata    = 32'hCAFE_0001;
    pready    = 1'b1;
    check("b2b_ready0", req_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge hclk);
      check("b2b_psel", psel, bb_sel[i]);
      check("b2b_penable", penable, bb_pen[i]);
      check("b2b_rsp_valid", rsp_valid, bb_rv[i]);
      check("b2b_rsp_rdata", rsp_rdata, bb_rd[i]);
      check("b2b_req_ready", req_ready, bb_rv[i]);
      if (i == 2) prdata = 32'hCAFE_0002;
      if (i == 3) req_valid = 1'b0;
    end
    $display("xfer RD addr=84000000 back-to-back x2");
    pready = 1'b0;
    idle_check();

    // Reset asserted during ACCESS
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h0000_0055;
    pready    = 1'b0;
    @(negedge hclk);
    req_valid = 1'b0;
    @(negedge hclk);
    check("rstmid_penable_pre", penable, 1);
    #1 hreset = 1'b1;
    #1;
    check("rstmid_psel", psel, 0);
    check("rstmid_penable", penable, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    @(negedge hclk);
    check("rstmid_rsp_valid2", rsp_valid, 0);
    check("rstmid_req_ready", req_ready, 1);
    hreset = 1'b0;
    @(negedge hclk);
    check("rstmid_rsp_valid3", rsp_valid, 0);
    check("rstmid_psel3", psel, 0);
    $display("xfer WR addr=80000020 aborted by reset");
    do_xfer(1'b1, 32'h8000_0024, 32'h0000_00AA, 32'h0, 0);
    idle_check();

    // Wait-state boundaries (these run as single-cycle ACCESS without PREADY_EN)
    do_xfer(1'b0, 32'h8400_0008, 32'h0, 32'h0000_3333, 3);
    idle_check();
    do_xfer(1'b0, 32'h8800_000C, 32'h0, 32'h0000_1616, TMO);
    idle_check();
    do_xfer(1'b0, 32'h8000_0000, 32'h0, 32'h7777_7777, 40);
    idle_check();

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [5:0]  top;
      int          r;
      int          w;
      r   = int'($urandom_range(0, 3));
      top = (r == 3) ? 6'($urandom) : 6'(32 + r);
      a   = {top, 26'($urandom)};
      w   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      do_xfer(1'($urandom), a, $urandom, $urandom, w);
      idle_check();
      repeat ($urandom_range(0, 2)) @(negedge hclk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
